// File: rtl/tick_scheduler.sv
// Multi-channel periodic event scheduler: a CE prescaler paces per-channel period
// counters, and a round-robin arbiter serialises expired channels onto one event port.
module tick_scheduler #(
  parameter int PRESCALE = 8,
  parameter int N_CH     = 4,
  parameter int PER_W    = 8,
  localparam int CH_W    = $clog2(N_CH),
  localparam int PS_W    = $clog2(PRESCALE)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CFG_VALID,
  output logic               CFG_READY,
  input  logic [CH_W-1:0]    CFG_CH,
  input  logic [PER_W-1:0]   CFG_PERIOD,
  input  logic               CFG_EN,
  output logic               EVT_VALID,
  input  logic               EVT_READY,
  output logic [CH_W-1:0]    EVT_CH,
  output logic [N_CH-1:0]    OVF,
  output logic               TICK,
  output logic               DBG_STATE
);

  // Both ports transfer on a cycle where valid & ready are high; once EVT_VALID
  // rises, EVT_VALID and EVT_CH hold until that transfer, and CFG_READY is
  // allowed to depend combinationally on CFG_CH.

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

  logic [PS_W-1:0]  psc_q;
  logic             tick_q;
  logic             cfg_rdy_q;
  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  ovf_q;
  logic [PER_W-1:0] period_q [N_CH];
  logic [PER_W-1:0] count_q  [N_CH];

  state_t           state_q;
  state_t           state_d;
  logic             evt_valid;
  logic [CH_W-1:0]  evt_ch_q;
  logic [CH_W-1:0]  last_q;

  logic             cfg_acc;
  logic             hs;
  logic [N_CH-1:0]  cfg_sel;
  logic [N_CH-1:0]  hs_sel;
  logic [N_CH-1:0]  fire;
  logic [N_CH-1:0]  pick_pend;
  logic [CH_W-1:0]  pick;
  logic             pick_found;

  // Prescaler: TICK is registered, so it follows the terminal count by one clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      psc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (psc_q == PS_LAST);
      psc_q  <= (psc_q == PS_LAST) ? '0 : psc_q + PS_W'(1);
    end
  end

  assign CFG_READY = cfg_rdy_q & ~(evt_valid & (CFG_CH == evt_ch_q));
  assign cfg_acc   = CFG_VALID & CFG_READY;
  assign hs        = evt_valid & EVT_READY;

  always_comb begin
    cfg_sel = '0;
    hs_sel  = '0;
    fire    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cfg_sel[i] = cfg_acc && (CFG_CH == CH_W'(i));
      hs_sel[i]  = hs && (evt_ch_q == CH_W'(i));
      fire[i]    = tick_q && en_q[i] && (count_q[i] == period_q[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_rdy_q <= 1'b0;
      en_q      <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      cfg_rdy_q <= ~cfg_acc;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_sel[i]) begin
          // A config write wins over a fire landing in the same cycle.
          en_q[i]     <= CFG_EN;
          period_q[i] <= CFG_PERIOD;
          count_q[i]  <= '0;
          pend_q[i]   <= 1'b0;
          ovf_q[i]    <= 1'b0;
        end else begin
          if (tick_q && en_q[i])
            count_q[i] <= fire[i] ? '0 : count_q[i] + PER_W'(1);
          if (fire[i]) begin
            pend_q[i] <= 1'b1;
            if (pend_q[i] && !hs_sel[i])
              ovf_q[i] <= 1'b1;
          end else if (hs_sel[i]) begin
            pend_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Round robin: first pending channel strictly after the last grant.
  assign pick_pend = pend_q & ~cfg_sel;

  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_q) + k) % N_CH;
      if (!pick_found && pick_pend[idx[CH_W-1:0]]) begin
        pick       = idx[CH_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = S_OFFER;
      S_OFFER: if (EVT_READY)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state_q == S_OFFER);
    DBG_STATE = (state_q == S_OFFER);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      evt_ch_q <= '0;
      last_q   <= CH_W'(N_CH - 1);
    end else begin
      if (state_q == S_IDLE && pick_found)
        evt_ch_q <= pick;
      if (hs)
        last_q <= evt_ch_q;
    end
  end

  assign EVT_VALID = evt_valid;
  assign EVT_CH    = evt_ch_q;
  assign OVF       = ovf_q;
  assign TICK      = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: hand-derived scenario table, directed corner
// sequences and a randomized run, all checked cycle by cycle against a model.
module tb_tick_scheduler;

  localparam int P  = 8;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0;
  logic          cfg_en = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [CW-1:0] evt_ch;
  logic [N-1:0]  ovf;
  logic          tick;
  logic          dbg_state;

  tick_scheduler #(.PRESCALE(P), .N_CH(N), .PER_W(W)) dut (
    .CLK(clk), .RST_N(rst_n),
    .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready), .CFG_CH(cfg_ch),
    .CFG_PERIOD(cfg_period), .CFG_EN(cfg_en),
    .EVT_VALID(evt_valid), .EVT_READY(evt_ready), .EVT_CH(evt_ch),
    .OVF(ovf), .TICK(tick), .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // State describes the cycle that the next negedge will observe.
  int m_cyc;
  bit m_busy;
  bit m_en [N];
  int m_per [N];
  int m_cnt [N];
  bit m_pend [N];
  bit m_ovf [N];
  bit m_valid;
  int m_ch;
  int m_last;

  int hs_cnt [N];
  int ticks_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_busy = 1'b1; m_valid = 1'b0; m_ch = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
    end
  endtask

  function automatic bit m_tick();
    return (m_cyc > 0) && (m_cyc % P == 0);
  endfunction

  function automatic bit m_cready(input int cch);
    return !m_busy && !(m_valid && cch == m_ch);
  endfunction

  function automatic logic [N-1:0] m_ovf_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit cv, input int cch, input int cper, input bit cen,
                      input bit er, output bit acc_o);
    bit tk, acc, hs, mine, f;
    bit op [N];
    int pick, c;
    @(negedge clk);
    check("tick", tick, m_tick());
    check("evt_valid", evt_valid, m_valid);
    check("dbg_state", dbg_state, m_valid);
    if (m_valid) check("evt_ch", evt_ch, m_ch);
    check("ovf", ovf, m_ovf_vec());
    if (tick === 1'b1) ticks_seen++;
    cfg_valid = cv; cfg_ch = CW'(cch); cfg_period = W'(cper); cfg_en = cen; evt_ready = er;
    #1;
    check("cfg_ready", cfg_ready, m_cready(cch));
    if (evt_valid === 1'b1 && er) hs_cnt[evt_ch]++;
    tk = m_tick(); acc = cv && m_cready(cch); hs = m_valid && er;
    pick = -1;
    for (int i = 0; i < N; i++) op[i] = m_pend[i];
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (pick < 0 && op[c] && !(acc && cch == c)) pick = c;
    end
    for (int i = 0; i < N; i++) begin
      mine = hs && (m_ch == i);
      if (acc && cch == i) begin
        m_en[i] = cen; m_per[i] = cper; m_cnt[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end else begin
        f = tk && m_en[i] && (m_cnt[i] == m_per[i]);
        if (tk && m_en[i]) m_cnt[i] = f ? 0 : m_cnt[i] + 1;
        if (mine) m_pend[i] = 0;
        if (f) begin
          if (op[i] && !mine) m_ovf[i] = 1;
          m_pend[i] = 1;
        end
      end
    end
    if (!m_valid) begin
      if (pick >= 0) begin m_valid = 1; m_ch = pick; end
    end else if (hs) begin
      m_valid = 0; m_last = m_ch;
    end
    m_busy = acc;
    m_cyc++;
    acc_o = acc;
  endtask

  task automatic idle(input bit er);
    bit a;
    step(1'b0, 0, 0, 1'b0, er, a);
  endtask

  task automatic cfg_write(input int ch, input int per, input bit en, input bit er);
    bit a;
    int n;
    a = 0; n = 0;
    while (!a && n < 20) begin
      step(1'b1, ch, per, en, er, a);
      n++;
    end
    check("cfg_accept", a, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 0; cfg_ch = '0; cfg_period = '0; cfg_en = 0; evt_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic [N-1:0]        cfg_mask;
    logic [N-1:0]        en_mask;
    logic [N-1:0][W-1:0] per;
    bit                  ready;
    int                  ticks;
    int                  exp_evt [N];
    logic [N-1:0]        exp_ovf;
  } row_t;

  row_t rows [6];

  initial begin
    bit a;
    int n;

    rows[0] = '{4'b0010, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd0}, 1'b1, 9,  '{0, 3, 0, 0},     4'b0000};
    rows[1] = '{4'b1101, 4'b1101, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 5,  '{5, 0, 5, 5},     4'b0000};
    rows[2] = '{4'b1111, 4'b1111, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 10, '{10, 10, 10, 10}, 4'b0000};
    rows[3] = '{4'b0011, 4'b0011, {8'd0, 8'd0, 8'd3, 8'd1}, 1'b1, 8,  '{4, 2, 0, 0},     4'b0000};
    rows[4] = '{4'b0001, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 3,  '{0, 0, 0, 0},     4'b0001};
    rows[5] = '{4'b0110, 4'b0010, {8'd0, 8'd4, 8'd0, 8'd0}, 1'b1, 4,  '{0, 4, 0, 0},     4'b0000};

    // Power-on reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick", tick, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_ch", evt_ch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cfg_ready", cfg_ready, 0);

    // Table: configure, run a fixed number of ticks, count handshakes per channel
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ticks_seen = 0;
      for (int c = 0; c < N; c++) hs_cnt[c] = 0;
      for (int c = 0; c < N; c++)
        if (rows[r].cfg_mask[c]) cfg_write(c, int'(rows[r].per[c]), rows[r].en_mask[c], rows[r].ready);
      n = 0;
      while (ticks_seen < rows[r].ticks + 1 && n < (rows[r].ticks + 3) * P) begin
        idle(rows[r].ready);
        n++;
      end
      check($sformatf("row%0d_ticks", r), ticks_seen, rows[r].ticks + 1);
      for (int c = 0; c < N; c++)
        check($sformatf("row%0d_evt_ch%0d", r, c), hs_cnt[c], rows[r].exp_evt[c]);
      check($sformatf("row%0d_ovf", r), ovf, rows[r].exp_ovf);
    end

    // Backpressure, config stall, then reset in the middle of an offer
    do_reset();
    cfg_write(0, 0, 1'b1, 1'b0);
    n = 0;
    while (evt_valid !== 1'b1 && n < 40) begin idle(1'b0); n++; end
    check("bp_valid_rise", evt_valid, 1);
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      check("bp_hold_valid", evt_valid, 1);
      check("bp_hold_ch", evt_ch, 0);
    end
    check("bp_ovf0", ovf[0], 1);
    step(1'b1, 0, 5, 1'b1, 1'b0, a);
    check("bp_stall_ready", cfg_ready, 0);
    check("bp_stall_acc", a, 0);
    step(1'b1, 1, 5, 1'b0, 1'b0, a);
    check("bp_other_ch_acc", a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_evt_valid", evt_valid, 0);
    check("async_tick", tick, 0);
    check("async_ovf", ovf, 0);
    check("async_evt_ch", evt_ch, 0);
    check("async_cfg_ready", cfg_ready, 0);
    do_reset();
    idle(1'b1);
    idle(1'b1);
    check("rst_release_cfg_ready", cfg_ready, 1);

    // Config lands on the same cycle ch2 fires, then back-to-back config
    do_reset();
    cfg_write(2, 1, 1'b1, 1'b1);
    n = 0;
    while (!(m_tick() && m_en[2] && m_cnt[2] == m_per[2]) && n < 100) begin idle(1'b1); n++; end
    check("col_found_fire", n < 100, 1);
    step(1'b1, 2, 1, 1'b1, 1'b1, a);
    check("col_accept", a, 1);
    step(1'b1, 1, 3, 1'b1, 1'b1, a);
    check("col_busy_ready", cfg_ready, 0);
    check("col_busy_acc", a, 0);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      check("col_no_evt", evt_valid, 0);
    end
    check("col_ovf2", ovf[2], 0);
    repeat (40) idle(1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, N - 1), $urandom_range(0, 3),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
